// File: rtl/rast_pkg.sv
// rast_pkg: shared rasteriser types and helpers.
// Provides the FSM state encoding, the edge accumulator width and the pixel coverage test.
package rast_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INIT, S_SCAN, S_DONE} state_t;
  function automatic int edge_w(input int cw);
    return 2 * cw + 3;
  endfunction
  // A pixel is covered if no edge value has the opposite sign to the triangle area.
  // Zero values count as inside, so shared edges are drawn by both triangles.
  function automatic logic inside_tri(input logic [2:0] neg, input logic [2:0] pos, input logic area_neg);
    return area_neg ? ~|pos : ~|neg;
  endfunction
endpackage

// File: rtl/edge_eval.sv
// edge_eval: step coefficients and start value of one edge function.
// Ports: i_xa/i_ya and i_xb/i_yb are the edge endpoints, i_xmin/i_ymin the scan origin.
// o_a is the x step, o_b the y step, and o_e the edge value at the origin.
module edge_eval import rast_pkg::*; #(
  parameter int COORD_W = 8,
  parameter int EW = edge_w(COORD_W)
) (
  input  logic [COORD_W-1:0]      i_xa,
  input  logic [COORD_W-1:0]      i_ya,
  input  logic [COORD_W-1:0]      i_xb,
  input  logic [COORD_W-1:0]      i_yb,
  input  logic [COORD_W-1:0]      i_xmin,
  input  logic [COORD_W-1:0]      i_ymin,
  output logic signed [COORD_W:0] o_a,
  output logic signed [COORD_W:0] o_b,
  output logic signed [EW-1:0]    o_e
);
  localparam int PW = 2 * COORD_W + 2;
  logic signed [PW-1:0] w_dx, w_dy, w_ex, w_ey;
  assign w_dx = $signed(PW'(i_xb)) - $signed(PW'(i_xa));
  assign w_dy = $signed(PW'(i_yb)) - $signed(PW'(i_ya));
  assign w_ex = $signed(PW'(i_xmin)) - $signed(PW'(i_xa));
  assign w_ey = $signed(PW'(i_ymin)) - $signed(PW'(i_ya));
  assign o_a = $signed({1'b0, i_ya}) - $signed({1'b0, i_yb});
  assign o_b = $signed({1'b0, i_xb}) - $signed({1'b0, i_xa});
  assign o_e = EW'(w_dx * w_ey) - EW'(w_dy * w_ex);
endmodule

// File: rtl/tri_raster.sv
// tri_raster: sequential triangle rasteriser emitting one covered pixel per cycle.
// Ports: clk/resetn (sync active-low); in_valid/in_ready with vertices x0..y2;
// out_valid/out_ready with out_x/out_y pixel; done pulses when a triangle ends.
module tri_raster import rast_pkg::*; #(
  parameter int COORD_W = 8,
  parameter bit CULL = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               done
);
  localparam int EW = edge_w(COORD_W);
  localparam int PW = 2 * COORD_W + 2;
  state_t r_state;
  logic [COORD_W-1:0] r_vx [3];
  logic [COORD_W-1:0] r_vy [3];
  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax, r_cx, r_cy;
  logic signed [COORD_W:0] w_a [3];
  logic signed [COORD_W:0] w_b [3];
  logic signed [EW-1:0] w_e0 [3];
  logic signed [EW-1:0] r_e [3];
  logic signed [EW-1:0] r_row [3];
  logic signed [EW-1:0] w_area;
  logic signed [PW-1:0] w_ux, w_uy, w_vx, w_vy;
  logic [2:0] w_neg, w_pos;
  logic r_area_neg, w_adv;
  for (genvar i = 0; i < 3; i++) begin : g_edge
    edge_eval #(.COORD_W(COORD_W), .EW(EW)) u_edge (
      .i_xa(r_vx[i]), .i_ya(r_vy[i]),
      .i_xb(r_vx[(i+1)%3]), .i_yb(r_vy[(i+1)%3]),
      .i_xmin(r_xmin), .i_ymin(r_ymin),
      .o_a(w_a[i]), .o_b(w_b[i]), .o_e(w_e0[i])
    );
    assign w_neg[i] = r_e[i][EW-1];
    assign w_pos[i] = !r_e[i][EW-1] && |r_e[i];
  end
  // Signed area: edge (v0,v1) evaluated at v2.
  assign w_ux = $signed(PW'(r_vx[1])) - $signed(PW'(r_vx[0]));
  assign w_uy = $signed(PW'(r_vy[1])) - $signed(PW'(r_vy[0]));
  assign w_vx = $signed(PW'(r_vx[2])) - $signed(PW'(r_vx[0]));
  assign w_vy = $signed(PW'(r_vy[2])) - $signed(PW'(r_vy[0]));
  assign w_area = EW'(w_ux * w_vy) - EW'(w_uy * w_vx);
  assign in_ready = r_state == S_IDLE;
  assign done = r_state == S_DONE;
  assign out_valid = r_state == S_SCAN && inside_tri(w_neg, w_pos, r_area_neg);
  assign out_x = r_cx;
  assign out_y = r_cy;
  assign w_adv = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_vx <= '{x0, x1, x2};
          r_vy <= '{y0, y1, y2};
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          r_xmin <= (r_vx[0] <= r_vx[1] && r_vx[0] <= r_vx[2]) ? r_vx[0] : (r_vx[1] <= r_vx[2]) ? r_vx[1] : r_vx[2];
          r_xmax <= (r_vx[0] >= r_vx[1] && r_vx[0] >= r_vx[2]) ? r_vx[0] : (r_vx[1] >= r_vx[2]) ? r_vx[1] : r_vx[2];
          r_ymin <= (r_vy[0] <= r_vy[1] && r_vy[0] <= r_vy[2]) ? r_vy[0] : (r_vy[1] <= r_vy[2]) ? r_vy[1] : r_vy[2];
          r_ymax <= (r_vy[0] >= r_vy[1] && r_vy[0] >= r_vy[2]) ? r_vy[0] : (r_vy[1] >= r_vy[2]) ? r_vy[1] : r_vy[2];
          r_state <= S_INIT;
        end
        S_INIT: begin
          r_e <= w_e0;
          r_row <= w_e0;
          r_area_neg <= w_area[EW-1];
          r_cx <= r_xmin;
          r_cy <= r_ymin;
          r_state <= (w_area == '0 || (CULL && w_area[EW-1])) ? S_DONE : S_SCAN;
        end
        S_SCAN: if (w_adv) begin
          // Bounds are checked before incrementing, so a box ending at the top coordinate never wraps.
          if (r_cx < r_xmax) begin
            r_cx <= r_cx + COORD_W'(1);
            for (int i = 0; i < 3; i++) r_e[i] <= r_e[i] + EW'(w_a[i]);
          end else if (r_cy < r_ymax) begin
            r_cx <= r_xmin;
            r_cy <= r_cy + COORD_W'(1);
            for (int i = 0; i < 3; i++) begin
              r_row[i] <= r_row[i] + EW'(w_b[i]);
              r_e[i] <= r_row[i] + EW'(w_b[i]);
            end
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_raster.sv
// tb_tri_raster: scoreboard bench driving a non-culling and a culling rasteriser side by side.
module tb_tri_raster;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic ir [2];
  logic ov [2];
  logic dn [2];
  logic [CW-1:0] ox [2];
  logic [CW-1:0] oy [2];
  int n_cmp = 0, n_err = 0, cyc = 0, acc_cyc = 0, mode = 0;
  int pops [2] = '{0, 0};
  logic [16:0] exp_q [2][$];
  logic pstall [2] = '{1'b0, 1'b0};
  logic pdone [2] = '{1'b0, 1'b0};
  logic [CW-1:0] px [2];
  logic [CW-1:0] py [2];
  logic [16:0] tok;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tri_raster #(.COORD_W(CW), .CULL(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[0]),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .out_valid(ov[0]), .out_ready(out_ready), .out_x(ox[0]), .out_y(oy[0]), .done(dn[0])
  );
  tri_raster #(.COORD_W(CW), .CULL(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[1]),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .out_valid(ov[1]), .out_ready(out_ready), .out_x(ox[1]), .out_y(oy[1]), .done(dn[1])
  );

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, c, act, exp, cyc);
    end
  endtask

  // Reference: brute-force scan of the bounding box with direct cross products.
  // Token bit16 marks end of triangle; bit0 on an end token means it must come 3 cycles after accept.
  task automatic push_exp(input int c, input int ax, input int ay, input int bx, input int by, input int qx, input int qy);
    int vx [3];
    int vy [3];
    int area, xmn, xmx, ymn, ymx, e, j;
    bit ok;
    vx = '{ax, bx, qx};
    vy = '{ay, by, qy};
    area = (bx - ax) * (qy - ay) - (by - ay) * (qx - ax);
    if (area == 0 || (c == 1 && area < 0)) begin
      exp_q[c].push_back(17'h10001);
      return;
    end
    xmn = vx[0]; xmx = vx[0]; ymn = vy[0]; ymx = vy[0];
    for (int i = 1; i < 3; i++) begin
      if (vx[i] < xmn) xmn = vx[i];
      if (vx[i] > xmx) xmx = vx[i];
      if (vy[i] < ymn) ymn = vy[i];
      if (vy[i] > ymx) ymx = vy[i];
    end
    for (int y = ymn; y <= ymx; y++)
      for (int x = xmn; x <= xmx; x++) begin
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
          j = (i + 1) % 3;
          e = (vx[j] - vx[i]) * (y - vy[i]) - (vy[j] - vy[i]) * (x - vx[i]);
          if (area > 0 ? e < 0 : e > 0) ok = 1'b0;
        end
        if (ok) exp_q[c].push_back({1'b0, 8'(x), 8'(y)});
      end
    exp_q[c].push_back(17'h10000);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (pstall[c]) begin
        chk("stall_valid", c, 32'(ov[c]), 32'd1);
        chk("stall_xy", c, 32'({ox[c], oy[c]}), 32'({px[c], py[c]}));
      end
      if (pdone[c]) chk("ready_after_done", c, 32'(ir[c]), 32'd1);
      if (ov[c] && out_ready) begin
        tok = exp_q[c].size() > 0 ? exp_q[c].pop_front() : 17'h1ffff;
        chk("pixel", c, 32'({1'b0, ox[c], oy[c]}), 32'(tok));
        pops[c]++;
      end
      if (dn[c]) begin
        tok = exp_q[c].size() > 0 ? exp_q[c].pop_front() : 17'h0;
        chk("done", c, 32'(dn[c]), 32'(tok[16]));
        if (tok[16] && tok[0]) chk("degenerate_latency", c, cyc - acc_cyc, 32'd3);
      end
      pstall[c] = resetn && ov[c] && !out_ready;
      pdone[c] = resetn && dn[c];
      px[c] = ox[c];
      py[c] = oy[c];
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
  end

  task automatic send(input int ax, input int ay, input int bx, input int by, input int qx, input int qy);
    int n = 0;
    while (!(ir[0] && ir[1]) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) chk("accept_timeout", 0, n, 0);
    {x0, y0, x1, y1, x2, y2} = {8'(ax), 8'(ay), 8'(bx), 8'(by), 8'(qx), 8'(qy)};
    in_valid = 1'b1;
    acc_cyc = cyc;
    push_exp(0, ax, ay, bx, by, qx, qy);
    push_exp(1, ax, ay, bx, by, qx, qy);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0 || !ir[0] || !ir[1]) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 0, n, 0);
  endtask

  initial begin
    int base, n, bx, by;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_in_ready", c, 32'(ir[c]), 32'd1);
      chk("rst_out_valid", c, 32'(ov[c]), 32'd0);
      chk("rst_done", c, 32'(dn[c]), 32'd0);
      chk("rst_xy", c, 32'({ox[c], oy[c]}), 32'd0);
    end
    resetn = 1'b1;
    mode = 0;
    base = pops[0];
    send(0, 0, 3, 0, 0, 3);
    wait_idle();
    chk("count_right_tri", 0, pops[0] - base, 32'd10);
    send(0, 0, 0, 3, 3, 0);
    wait_idle();
    send(0, 0, 2, 2, 4, 4);
    wait_idle();
    mode = 1;
    send(0, 0, 3, 0, 0, 3);
    wait_idle();
    mode = 2;
    base = pops[0];
    send(255, 255, 253, 255, 255, 253);
    wait_idle();
    chk("count_corner", 0, pops[0] - base, 32'd6);
    mode = 0;
    base = pops[0];
    send(0, 0, 3, 0, 0, 3);
    n = 0;
    while (pops[0] < base + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("mid_scan_timeout", 0, n, 0);
    resetn = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      exp_q[c].delete();
      chk("midrst_out_valid", c, 32'(ov[c]), 32'd0);
      chk("midrst_done", c, 32'(dn[c]), 32'd0);
      chk("midrst_in_ready", c, 32'(ir[c]), 32'd1);
      chk("midrst_xy", c, 32'({ox[c], oy[c]}), 32'd0);
    end
    resetn = 1'b1;
    base = pops[0];
    send(0, 0, 3, 0, 0, 3);
    wait_idle();
    chk("count_after_reset", 0, pops[0] - base, 32'd10);
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 2);
      bx = $urandom_range(0, 240);
      by = $urandom_range(0, 240);
      send(bx + $urandom_range(0, 15), by + $urandom_range(0, 15),
           bx + $urandom_range(0, 15), by + $urandom_range(0, 15),
           bx + $urandom_range(0, 15), by + $urandom_range(0, 15));
    end
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
